seq_divider: RTL and testbench

//   Parametrised multi-cycle unsigned restoring divider. Successor to the 4-bit

---
 rtl/seq_divider_if.sv | 14 +
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider: operands in, results and status out.
interface seq_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (output start, A, B, input busy, done, Q, R, div_by_zero);
  modport slave  (input start, A, B, output busy, done, Q, R, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Optional two's-complement mode via SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;     // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, rem_sub, rem_nxt;
  logic             ge;
  logic [WIDTH-1:0] q_nxt, q_fin, r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  always_comb begin
    a_mag = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    b_mag = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
  end
`else
  always_comb begin
    a_mag = bus.A;
    b_mag = bus.B;
  end
`endif

  assign accept = bus.start && (state != CALC);

  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], a_sh[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, b_r});
    rem_sub = rem_sh - {1'b0, b_r};
    rem_nxt = ge ? rem_sub : rem_sh;
    q_nxt   = {a_sh[WIDTH-2:0], ge};
`ifdef SEQ_DIVIDER_SIGNED_EN
    // Truncating division: quotient sign from A^B, remainder follows A.
    q_fin   = neg_q ? (~q_nxt + 1'b1) : q_nxt;
    r_fin   = neg_r ? (~rem_nxt[WIDTH-1:0] + 1'b1) : rem_nxt[WIDTH-1:0];
`else
    q_fin   = q_nxt;
    r_fin   = rem_nxt[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      a_sh            <= '0;
      b_r             <= '0;
      rem             <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.Q           <= '0;
      bus.R           <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        CALC: begin
          a_sh <= q_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.Q           <= q_fin;
            bus.R           <= r_fin;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            if (bus.B == '0) begin
              // Divide by zero short-circuits the iteration entirely.
              bus.Q           <= '1;
              bus.R           <= bus.A;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= DONE;
            end else begin
              a_sh     <= a_mag;
              b_r      <= b_mag;
              rem      <= '0;
              cnt      <= CW'(WIDTH - 1);
              bus.busy <= 1'b1;
              state    <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
              neg_r    <= bus.A[WIDTH-1];
`endif
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=4: handshake timing, results, div-by-zero, reset.
module tb_seq_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count edges after accept until done; bounded so a stuck DUT still reports.
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    chk(tag, n, exp_lat);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz);
    chk({tag, ".Q"}, bus.Q, q);
    chk({tag, ".R"}, bus.R, r);
    chk({tag, ".dbz"}, bus.div_by_zero, dz);
  endtask

  initial begin
    int dones;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk_res("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick();

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(4'b1001, 4'd2);              // -7 / 2
    wait_done("s1.lat", 4);
    chk_res("s1", 4'b1101, 4'b1111, 0); // -3, -1
    run_op(4'b1000, 4'b1111);           // MIN / -1
    wait_done("s2.lat", 4);
    chk_res("s2", 4'b1000, 4'd0, 0);
    run_op(4'd6, 4'b1110);              // 6 / -2
    wait_done("s3.lat", 4);
    chk_res("s3", 4'b1101, 4'd0, 0);
    run_op(4'b1010, 4'd0);              // -6 / 0
    chk("s4.done", bus.done, 1);
    chk_res("s4", 4'b1111, 4'b1010, 1);
`else
    // Basic op, exact latency of WIDTH edges after accept.
    run_op(4'd9, 4'd2);
    chk("t1.busy", bus.busy, 1);
    chk("t1.done0", bus.done, 0);
    wait_done("t1.lat", 4);
    chk("t1.busy_end", bus.busy, 0);
    chk_res("t1", 4'd4, 4'd1, 0);

    // Back-to-back: accepted on the edge where done would otherwise fall.
    run_op(4'd15, 4'd3);
    chk("t2.done_drop", bus.done, 0);
    chk("t2.busy", bus.busy, 1);
    chk("t2.Q_held", bus.Q, 4);
    wait_done("t2.lat", 4);
    chk_res("t2", 4'd5, 4'd0, 0);

    // Divide by zero, then recovery clears the flag at the next completion only.
    run_op(4'd8, 4'd0);
    chk("t3.done", bus.done, 1);
    chk("t3.busy", bus.busy, 0);
    chk_res("t3", 4'd15, 4'd8, 1);
    tick();
    chk("t3.done_pulse", bus.done, 0);
    run_op(4'd5, 4'd3);
    chk("t4.dbz_held", bus.div_by_zero, 1);
    wait_done("t4.lat", 4);
    chk_res("t4", 4'd1, 4'd2, 0);

    // Start while busy is ignored.
    run_op(4'd10, 4'd4);
    bus.A     = 4'd1;
    bus.B     = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("t5.lat", 3);
    chk_res("t5", 4'd2, 4'd2, 0);

    // Boundary operands.
    run_op(4'd0, 4'd5);
    wait_done("t6.lat", 4);
    chk_res("t6", 4'd0, 4'd0, 0);
    run_op(4'd3, 4'd7);
    wait_done("t7.lat", 4);
    chk_res("t7", 4'd0, 4'd3, 0);
    run_op(4'd15, 4'd1);
    wait_done("t8.lat", 4);
    chk_res("t8", 4'd15, 4'd0, 0);
    run_op(4'd14, 4'd15);
    wait_done("t9.lat", 4);
    chk_res("t9", 4'd0, 4'd14, 0);
`endif

    // Reset on the second CALC edge discards the operation.
    run_op(4'd13, 4'd2);
    tick();
    rst_n = 1'b0;
    tick();
    chk("trst.busy", bus.busy, 0);
    chk("trst.done", bus.done, 0);
    chk("trst.Q", bus.Q, 0);
    chk("trst.R", bus.R, 0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("trst.no_done", dones, 0);

    // Reset wins over a concurrent start.
    rst_n     = 1'b0;
    bus.A     = 4'd6;
    bus.B     = 4'd0;
    bus.start = 1'b1;
    tick();
    chk("tpri.done", bus.done, 0);
    chk("tpri.dbz", bus.div_by_zero, 0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
